// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks the register file read port in ascending address order on a start
// pulse and streams each captured word out over a valid/ready handshake,
// tagged with its address and a last-word flag.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; outputs quiet, payload holds
//   READ   | rf_addr stable for a full cycle; word captured on exit
//   SEND   | out_valid high, payload held until the sink accepts it
//   DONE   | one-cycle done pulse after the final word was accepted
module regfile_dump_reader #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 5,
  parameter int SKIP_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [XLEN-1:0]   rf_data,
  output logic [XLEN-1:0]   out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The final address is found by compare so the walk never relies on wrap.
  localparam logic [ADDR_W-1:0] LP_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] LP_FIRST = (SKIP_ZERO != 0) ? ADDR_W'(1) : ADDR_W'(0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [ADDR_W-1:0] w_rf_addr_nxt;
  logic [XLEN-1:0]   r_out_data;
  logic [XLEN-1:0]   w_out_data_nxt;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] w_out_addr_nxt;
  logic              r_out_valid;
  logic              w_out_valid_nxt;
  logic              r_out_last;
  logic              w_out_last_nxt;
  logic              w_handshake;

  assign w_handshake = r_out_valid && out_ready;

  // State and datapath registers; reset drops any dump in flight at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rf_addr   <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rf_addr   <= w_rf_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  // Next-state and datapath update; abort beats a same-cycle handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_rf_addr_nxt   = r_rf_addr;
    w_out_data_nxt  = r_out_data;
    w_out_addr_nxt  = r_out_addr;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;

    case (r_state)
      S_IDLE: begin
        w_out_valid_nxt = 1'b0;
        if (start && !abort) begin
          w_rf_addr_nxt = LP_FIRST;
          w_state_nxt   = S_READ;
        end
      end

      S_READ: begin
        if (abort) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          // Sampled on this edge, so a same-edge write to rf_addr is not seen.
          w_out_data_nxt  = rf_data;
          w_out_addr_nxt  = r_rf_addr;
          w_out_last_nxt  = (r_rf_addr == LP_LAST);
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_SEND;
        end
      end

      S_SEND: begin
        if (abort) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else if (w_handshake) begin
          w_out_valid_nxt = 1'b0;
          if (r_out_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_rf_addr_nxt = r_rf_addr + ADDR_W'(1);
            w_state_nxt   = S_READ;
          end
        end
      end

      S_DONE: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end

      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  assign rf_addr   = r_rf_addr;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state == S_READ) || (r_state == S_SEND);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a register file model with one write port
// feeding two readers (SKIP_ZERO=1 and SKIP_ZERO=0), a scenario table and a
// handful of directed corner-case sequences.
module tb_regfile_dump_reader;

  logic        clk;
  logic        reset_n;
  logic        start     [2];
  logic        abort     [2];
  logic        ready     [2];
  logic [4:0]  rf_addr_w [2];
  logic [31:0] rf_data_w [2];
  logic [31:0] out_data_w[2];
  logic [4:0]  out_addr_w[2];
  logic        out_valid_w[2];
  logic        out_last_w[2];
  logic        busy_w    [2];
  logic        done_w    [2];

  logic [31:0] mem      [32];
  logic [31:0] load_img [32];
  logic        load_req;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] di3;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] last_seen[32];

  // Index 0: SKIP_ZERO=1 reader, index 1: SKIP_ZERO=0 reader.
  regfile_dump_reader #(.XLEN(32), .ADDR_W(5), .SKIP_ZERO(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort[0]),
    .rf_addr(rf_addr_w[0]), .rf_data(rf_data_w[0]),
    .out_data(out_data_w[0]), .out_addr(out_addr_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(ready[0]),
    .out_last(out_last_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  regfile_dump_reader #(.XLEN(32), .ADDR_W(5), .SKIP_ZERO(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort[1]),
    .rf_addr(rf_addr_w[1]), .rf_data(rf_data_w[1]),
    .out_data(out_data_w[1]), .out_addr(out_addr_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(ready[1]),
    .out_last(out_last_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  assign rf_data_w[0] = mem[rf_addr_w[0]];
  assign rf_data_w[1] = mem[rf_addr_w[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: bulk image load, else the single we3 write port.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) mem[i] <= load_img[i];
    end else if (we3) begin
      mem[a3] <= di3;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic load_image(input int rand_mode);
    for (int i = 0; i < 32; i++)
      load_img[i] = (rand_mode != 0) ? $urandom : 32'(i * 3);
    load_img[0] = 32'd0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic check_quiet(input int d, input string tag);
    check({tag, "_rf_addr"},   rf_addr_w[d],   0);
    check({tag, "_out_data"},  out_data_w[d],  0);
    check({tag, "_out_addr"},  out_addr_w[d],  0);
    check({tag, "_out_valid"}, out_valid_w[d], 0);
    check({tag, "_out_last"},  out_last_w[d],  0);
    check({tag, "_busy"},      busy_w[d],      0);
    check({tag, "_done"},      done_w[d],      0);
  endtask

  // Run one dump on reader d. Expected stream: every address from the first
  // one to 31, each carrying the register value as it stood when the dump
  // began (writes land no earlier than the word's own READ edge).
  task automatic run_dump(input int d, input int stall_pct,
                          input int stall_addr, input int stall_len,
                          input int wr_addr, input logic [31:0] wr_val,
                          input int abort_addr, input int restart_addr,
                          output int words, output int first_addr);
    logic [31:0] snap[32];
    logic [31:0] pd;
    logic [4:0]  pa;
    logic        pl, v, r, hs;
    int exp_a, idx, hs_idx, last_hs, stalls, stall_cnt, done_idx, done_cnt;
    bit prev_valid, prev_hs, fin, restarted, bad;
    for (int i = 0; i < 32; i++) snap[i] = mem[i];
    exp_a = (d == 0) ? 1 : 0;
    words = 0; first_addr = -1; hs_idx = -1; last_hs = -1; stalls = 0;
    stall_cnt = 0; done_idx = -1; done_cnt = 0; prev_valid = 0; prev_hs = 0;
    fin = 0; restarted = 0; pd = '0; pa = '0; pl = 1'b0;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    idx = 1;
    while (!fin && idx < 2000) begin
      we3 = 1'b0; start[d] = 1'b0; abort[d] = 1'b0;
      v = out_valid_w[d];
      if (done_w[d]) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
      end else if (done_idx >= 0) begin
        fin = 1;
      end
      if (v && prev_valid && !prev_hs) begin
        check("hold_data", out_data_w[d], pd);
        check("hold_addr", out_addr_w[d], pa);
        check("hold_last", out_last_w[d], pl);
      end
      if (v && !prev_valid) begin
        if (words == 0) check("first_valid_latency", idx, 2);
        else            check("next_word_gap", idx - hs_idx, 2);
      end
      r = ($urandom_range(0, 99) >= stall_pct);
      if (v && int'(out_addr_w[d]) == stall_addr && stall_cnt < stall_len) begin
        r = 1'b0; stall_cnt++;
      end
      ready[d] = r;
      if (busy_w[d] && !v && int'(rf_addr_w[d]) == wr_addr) begin
        we3 = 1'b1; a3 = 5'(wr_addr); di3 = wr_val;
      end
      if (v && int'(out_addr_w[d]) == restart_addr && !restarted) begin
        start[d] = 1'b1; restarted = 1;
      end
      if (v && int'(out_addr_w[d]) == abort_addr) begin
        abort[d] = 1'b1; ready[d] = 1'b1;
        @(negedge clk);
        abort[d] = 1'b0; ready[d] = 1'b0;
        check("abort_valid", out_valid_w[d], 0);
        check("abort_busy",  busy_w[d], 0);
        check("abort_done",  done_w[d], 0);
        bad = 0;
        ready[d] = 1'b1;
        repeat (6) begin
          @(negedge clk);
          if (done_w[d] || out_valid_w[d] || busy_w[d]) bad = 1;
        end
        ready[d] = 1'b0;
        check("abort_stays_idle", bad, 0);
        return;
      end
      hs = v && ready[d];
      if (hs) begin
        check("word_addr", out_addr_w[d], exp_a);
        check("word_data", out_data_w[d], snap[exp_a]);
        check("word_last", out_last_w[d], (exp_a == 31));
        last_seen[out_addr_w[d]] = out_data_w[d];
        if (words == 0) first_addr = int'(out_addr_w[d]);
        words++;
        hs_idx = idx;
        if (exp_a == 31) last_hs = idx;
        exp_a++;
      end
      if (v && !ready[d]) stalls++;
      prev_valid = v; prev_hs = hs;
      pd = out_data_w[d]; pa = out_addr_w[d]; pl = out_last_w[d];
      @(negedge clk);
      idx++;
    end
    we3 = 1'b0; ready[d] = 1'b0; start[d] = 1'b0;
    check("dump_finished_in_budget", fin, 1);
    check("done_pulse_width", done_cnt, 1);
    check("done_after_last", (done_idx - last_hs >= 1) && (done_idx - last_hs <= 2), 1);
    check("word_count", words, (d == 0) ? 31 : 32);
    check("cycle_cost", last_hs, 2 * words + stalls);
    check("idle_after_done", busy_w[d], 0);
  endtask

  typedef struct {
    int d;
    int stall_pct;
    int rand_mem;
    int exp_words;
    int exp_first;
  } vec_t;

  vec_t vecs[5];
  int   words, first, bad;

  initial begin
    reset_n = 1'b0; load_req = 1'b0; we3 = 1'b0; a3 = '0; di3 = '0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; ready[i] = 1'b0;
    end
    for (int i = 0; i < 32; i++) begin
      load_img[i] = '0; last_seen[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_quiet(0, "reset1");
    check_quiet(1, "reset0");
    reset_n = 1'b1;

    vecs[0] = '{d: 0, stall_pct: 0,  rand_mem: 0, exp_words: 31, exp_first: 1};
    vecs[1] = '{d: 0, stall_pct: 30, rand_mem: 1, exp_words: 31, exp_first: 1};
    vecs[2] = '{d: 1, stall_pct: 0,  rand_mem: 0, exp_words: 32, exp_first: 0};
    vecs[3] = '{d: 1, stall_pct: 50, rand_mem: 1, exp_words: 32, exp_first: 0};
    vecs[4] = '{d: 0, stall_pct: 70, rand_mem: 1, exp_words: 31, exp_first: 1};

    for (int k = 0; k < 5; k++) begin
      load_image(vecs[k].rand_mem);
      run_dump(vecs[k].d, vecs[k].stall_pct, -1, 0, -1, 32'd0, -1, -1, words, first);
      check($sformatf("vec%0d_words", k), words, vecs[k].exp_words);
      check($sformatf("vec%0d_first", k), first, vecs[k].exp_first);
    end
    check("skip0_word0_data", last_seen[0], 0);

    // Ten-cycle stall on address 5.
    load_image(0);
    run_dump(0, 0, 5, 10, -1, 32'd0, -1, -1, words, first);
    check("stall_addr5_data", last_seen[5], 15);

    // Write to reg 7 on the edge that ends its READ: old value is dumped.
    run_dump(0, 0, -1, 0, 7, 32'd69, -1, -1, words, first);
    check("snapshot_reg7_old", last_seen[7], 21);
    run_dump(0, 0, -1, 0, -1, 32'd0, -1, -1, words, first);
    check("snapshot_reg7_new", last_seen[7], 69);

    // Abort while SEND for address 10 with the sink ready.
    load_image(0);
    run_dump(0, 0, -1, 0, -1, 32'd0, 10, -1, words, first);
    check("abort_words_sent", words, 9);
    run_dump(0, 0, -1, 0, -1, 32'd0, -1, -1, words, first);
    check("restart_first_addr", first, 1);

    // start during SEND is ignored and does not queue another dump.
    run_dump(0, 20, -1, 0, -1, 32'd0, -1, 15, words, first);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy_w[0]) bad = 1;
    end
    check("no_queued_restart", bad, 0);

    // start together with abort in IDLE does nothing.
    @(negedge clk);
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort[0] = 1'b0;
    check("start_abort_idle_busy", busy_w[0], 0);
    @(negedge clk);
    check("start_abort_idle_valid", out_valid_w[0], 0);

    // Asynchronous reset while address 12 is on offer.
    load_image(0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    bad = 1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid_w[0] && out_addr_w[0] == 5'd12) begin
        bad = 0;
        break;
      end
      ready[0] = 1'b1;
      @(negedge clk);
    end
    ready[0] = 1'b0;
    check("reach_addr12", bad, 0);
    #2 reset_n = 1'b0;
    #1 check_quiet(0, "async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    ready[0] = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid_w[0] || busy_w[0] || done_w[0]) bad = 1;
    end
    ready[0] = 1'b0;
    check("idle_after_reset", bad, 0);
    run_dump(0, 10, -1, 0, -1, 32'd0, -1, -1, words, first);
    check("dump_after_reset_first", first, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
